// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: multi-lane enqueue/dequeue FIFO of {pc_plus4, instr}.
// Heads are shown combinationally from registered storage; fetch_ready depends on occupancy only.
module if_id_queue #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 32,
  parameter int LANES       = 2,
  parameter int DEPTH       = 4,
  localparam int CW         = $clog2(LANES + 1),
  localparam int OW         = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [CW-1:0]                fetch_cnt,
  input  logic [LANES*PC_WIDTH-1:0]    fetch_pc_plus4,
  input  logic [LANES*INSTR_WIDTH-1:0] fetch_instr,
  output logic                         fetch_ready,
  input  logic [CW-1:0]                deq_cnt,
  output logic [LANES-1:0]             id_valid,
  output logic [LANES*PC_WIDTH-1:0]    id_pc_plus4,
  output logic [LANES*INSTR_WIDTH-1:0] id_instr,
  output logic [OW-1:0]                occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_WIDTH-1:0]    r_pc    [DEPTH];
  logic [INSTR_WIDTH-1:0] r_instr [DEPTH];
  logic [PW-1:0]          r_head;
  logic [PW-1:0]          r_tail;
  logic [OW-1:0]          r_occ;

  logic                   w_ready;
  logic [OW-1:0]          w_enq;
  logic [OW-1:0]          w_deq;

  assign w_ready = (r_occ <= OW'(DEPTH - LANES));

  // Clamp both counts to LANES; dequeue is further limited to what is stored.
  always_comb begin
    w_enq = '0;
    if (w_ready) begin
      w_enq = (fetch_cnt > CW'(LANES)) ? OW'(LANES) : OW'(fetch_cnt);
    end
    w_deq = (deq_cnt > CW'(LANES)) ? OW'(LANES) : OW'(deq_cnt);
    if (w_deq > r_occ) begin
      w_deq = r_occ;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_head <= r_head + PW'(w_deq);
      r_tail <= r_tail + PW'(w_enq);
      r_occ  <= r_occ + w_enq - w_deq;
    end
  end

  // Flush only clears validity; payload stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (!flush) begin
      for (int i = 0; i < LANES; i++) begin
        if (OW'(i) < w_enq) begin
          r_pc[r_tail + PW'(i)]    <= fetch_pc_plus4[i*PC_WIDTH +: PC_WIDTH];
          r_instr[r_tail + PW'(i)] <= fetch_instr[i*INSTR_WIDTH +: INSTR_WIDTH];
        end
      end
    end
  end

  always_comb begin
    id_valid    = '0;
    id_pc_plus4 = '0;
    id_instr    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_occ > OW'(i)) begin
        id_valid[i]                               = 1'b1;
        id_pc_plus4[i*PC_WIDTH +: PC_WIDTH]       = r_pc[r_head + PW'(i)];
        id_instr[i*INSTR_WIDTH +: INSTR_WIDTH]    = r_instr[r_head + PW'(i)];
      end
    end
  end

  assign fetch_ready = w_ready;
  assign occupancy   = r_occ;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (LANES=2, DEPTH=4): a queue-based reference model
// checked every negedge, plus literal expectations for the key scenarios.
module tb_if_id_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [1:0]  fetch_cnt;
  logic [19:0] fetch_pc_plus4;
  logic [63:0] fetch_instr;
  logic        fetch_ready;
  logic [1:0]  deq_cnt;
  logic [1:0]  id_valid;
  logic [19:0] id_pc_plus4;
  logic [63:0] id_instr;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [41:0] model_q[$];

  if_id_queue #(
    .PC_WIDTH   (10),
    .INSTR_WIDTH(32),
    .LANES      (2),
    .DEPTH      (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .fetch_cnt     (fetch_cnt),
    .fetch_pc_plus4(fetch_pc_plus4),
    .fetch_instr   (fetch_instr),
    .fetch_ready   (fetch_ready),
    .deq_cnt       (deq_cnt),
    .id_valid      (id_valid),
    .id_pc_plus4   (id_pc_plus4),
    .id_instr      (id_instr),
    .occupancy     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain FIFO of {pc, instr}; dequeue comes from the pre-edge contents.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      int sz, enq, deq;
      sz  = model_q.size();
      enq = ((4 - sz) >= 2) ? ((int'(fetch_cnt) > 2) ? 2 : int'(fetch_cnt)) : 0;
      deq = (int'(deq_cnt) > 2) ? 2 : int'(deq_cnt);
      if (deq > sz) deq = sz;
      for (int k = 0; k < deq; k++) void'(model_q.pop_front());
      for (int k = 0; k < enq; k++)
        model_q.push_back({fetch_pc_plus4[k*10 +: 10], fetch_instr[k*32 +: 32]});
    end
  end

  task automatic check_model();
    logic [1:0]  ev;
    logic [19:0] ep;
    logic [63:0] ei;
    int          sz;
    sz = model_q.size();
    ev = '0;
    ep = '0;
    ei = '0;
    for (int k = 0; k < 2; k++) begin
      if (k < sz) begin
        ev[k]         = 1'b1;
        ep[k*10 +: 10] = model_q[k][41:32];
        ei[k*32 +: 32] = model_q[k][31:0];
      end
    end
    chk("model_occupancy", 64'(occupancy), 64'(sz));
    chk("model_fetch_ready", 64'(fetch_ready), 64'((4 - sz) >= 2));
    chk("model_id_valid", 64'(id_valid), 64'(ev));
    chk("model_id_pc_plus4", 64'(id_pc_plus4), 64'(ep));
    chk("model_id_instr", id_instr, ei);
  endtask

  always @(negedge clk) check_model();

  task automatic cyc(input int fc, input logic [9:0] p0, input logic [9:0] p1,
                     input logic [31:0] i0, input logic [31:0] i1, input int dc,
                     input logic fl);
    fetch_cnt      = 2'(fc);
    fetch_pc_plus4 = {p1, p0};
    fetch_instr    = {i1, i0};
    deq_cnt        = 2'(dc);
    flush          = fl;
    @(posedge clk);
    #1;
    fetch_cnt      = '0;
    fetch_pc_plus4 = '0;
    fetch_instr    = '0;
    deq_cnt        = '0;
    flush          = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    fetch_cnt      = '0;
    fetch_pc_plus4 = '0;
    fetch_instr    = '0;
    deq_cnt        = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_id_valid", 64'(id_valid), 64'd0);
    chk("reset_fetch_ready", 64'(fetch_ready), 64'd1);
    chk("reset_occupancy", 64'(occupancy), 64'd0);
    reset = 1'b0;

    // Two-lane enqueue, visible next cycle
    cyc(2, 10'h004, 10'h008, 32'h00000013, 32'h00100093, 0, 1'b0);
    chk("enq2_valid", 64'(id_valid), 64'h3);
    chk("enq2_pc0", 64'(id_pc_plus4[9:0]), 64'h004);
    chk("enq2_pc1", 64'(id_pc_plus4[19:10]), 64'h008);
    chk("enq2_instr1", 64'(id_instr[63:32]), 64'h00100093);
    chk("enq2_occ", 64'(occupancy), 64'd2);

    // Simultaneous 1-in/1-out at occupancy 2
    cyc(1, 10'h00c, 10'h000, 32'h00208113, 32'h0, 1, 1'b0);
    chk("swap_occ", 64'(occupancy), 64'd2);
    chk("swap_pc0", 64'(id_pc_plus4[9:0]), 64'h008);
    chk("swap_pc1", 64'(id_pc_plus4[19:10]), 64'h00c);

    // Occupancy 3 blocks fetch; enqueue ignored while dequeuing 2
    cyc(1, 10'h010, 10'h000, 32'h00310193, 32'h0, 0, 1'b0);
    chk("occ3_occ", 64'(occupancy), 64'd3);
    chk("occ3_ready", 64'(fetch_ready), 64'd0);
    cyc(2, 10'h014, 10'h018, 32'hdeadbeef, 32'hcafef00d, 2, 1'b0);
    chk("blocked_occ", 64'(occupancy), 64'd1);
    chk("blocked_ready", 64'(fetch_ready), 64'd1);
    chk("blocked_pc0", 64'(id_pc_plus4[9:0]), 64'h010);
    chk("blocked_valid", 64'(id_valid), 64'h1);
    cyc(0, 10'h0, 10'h0, 32'h0, 32'h0, 2, 1'b0);
    chk("drain_occ", 64'(occupancy), 64'd0);

    // Interleaved single enqueue/dequeue across the index wrap
    for (int k = 0; k < 6; k++) begin
      cyc(1, 10'(10'h100 + 4 * k), 10'h0, 32'(32'h1000 + k), 32'h0, 0, 1'b0);
      chk("wrap_pc0", 64'(id_pc_plus4[9:0]), 64'(10'h100 + 4 * k));
      chk("wrap_instr0", 64'(id_instr[31:0]), 64'(32'h1000 + k));
      cyc(0, 10'h0, 10'h0, 32'h0, 32'h0, 1, 1'b0);
      chk("wrap_empty", 64'(id_valid), 64'd0);
    end

    // Flush beats a concurrent enqueue at occupancy 3
    cyc(2, 10'h040, 10'h044, 32'h11, 32'h22, 0, 1'b0);
    cyc(1, 10'h048, 10'h0, 32'h33, 32'h0, 0, 1'b0);
    chk("preflush_occ", 64'(occupancy), 64'd3);
    cyc(2, 10'h04c, 10'h050, 32'h44, 32'h55, 1, 1'b1);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_valid", 64'(id_valid), 64'd0);
    chk("flush_pc", 64'(id_pc_plus4), 64'd0);
    chk("flush_instr", id_instr, 64'd0);

    // fetch_cnt=3 behaves as 2, then fill to 4
    cyc(3, 10'h200, 10'h204, 32'haa, 32'hbb, 0, 1'b0);
    chk("clamp_occ", 64'(occupancy), 64'd2);
    cyc(2, 10'h208, 10'h20c, 32'hcc, 32'hdd, 0, 1'b0);
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_ready", 64'(fetch_ready), 64'd0);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_occ", 64'(occupancy), 64'd0);
    chk("async_rst_valid", 64'(id_valid), 64'd0);
    chk("async_rst_pc", 64'(id_pc_plus4), 64'd0);
    chk("async_rst_ready", 64'(fetch_ready), 64'd1);
    check_model();
    #3;
    reset = 1'b0;

    // First edge after reset accepts an enqueue
    cyc(1, 10'h300, 10'h0, 32'h77, 32'h0, 0, 1'b0);
    chk("post_rst_occ", 64'(occupancy), 64'd1);
    chk("post_rst_pc0", 64'(id_pc_plus4[9:0]), 64'h300);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
